// File: rtl/down_counter_if.sv
// Control/status bundle for down_counter.
// The master side drives load/load_val/enable/clear; the slave (the counter)
// returns count and the registered status flags.
interface down_counter_if #(
  parameter int WIDTH = 8
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             underflow;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, enable, clear,
    input  count, underflow, busy, done
  );

  modport slave (
    input  load, load_val, enable, clear,
    output count, underflow, busy, done
  );

endinterface

// File: rtl/down_counter.sv
// Loadable down-counter with terminal-count detection.
//
// Build option: define DOWN_COUNTER_RELOAD_EN for auto-reload mode, where the
// terminal count reloads the last loaded value and the counter keeps running.
// Without it the counter is one-shot: terminal count parks in DONE at zero.
//
// Input priority every cycle: clear > load > enable.
// All outputs are registered; they change one clock after the sampled inputs.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | after reset or clear; count holds, enable ignored
//  RUN    | counting; enable decrements, terminal count at count==0
//  DONE   | one-shot finished; count holds 0 until load or clear
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             at_zero;
  logic             step;

`ifdef DOWN_COUNTER_RELOAD_EN
  // The reload value only matters when the terminal count wraps back to it.
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign at_zero = (count_q == '0);
  // A decrement/terminal event is only possible in RUN with no higher-priority input.
  assign step    = (state_q == S_RUN) && bus.enable && !bus.clear && !bus.load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear and load apply from any state, enable only in RUN.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else if (bus.load) begin
      state_d = S_RUN;
    end else if (step && at_zero) begin
`ifdef DOWN_COUNTER_RELOAD_EN
      state_d = S_RUN;
`else
      state_d = S_DONE;
`endif
    end
  end

  // Datapath next values: count, reload capture and the terminal-count pulse.
  always_comb begin
    count_d     = count_q;
    underflow_d = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_d    = reload_q;
`endif
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_d = bus.load_val;
`endif
    end else if (step) begin
      if (at_zero) begin
        underflow_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
`endif
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // Status flags are decoded from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef DOWN_COUNTER_RELOAD_EN
  // Reload value register, cleared by reset along with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.count     = count_q;
  assign bus.underflow = underflow_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port load  input  1  load load_val into count and reload register; start run.
REQ-005 Port load_val  input  WIDTH  value captured on load.
REQ-006 Port enable  input  1  decrement qualifier, effective only in RUN.
REQ-007 Port clear  input  1  abort to IDLE and zero count.
REQ-008 Port count  output  WIDTH  registered current count.
REQ-009 Port underflow  output  1  registered one-cycle pulse on terminal count.
REQ-010 Port busy  output  1  registered; high in RUN.
REQ-011 Port done  output  1  registered; high in DONE.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 Input priority SHALL be clear > load > enable, evaluated every cycle.
REQ-014 clear in any state SHALL set count=0 and state=IDLE next cycle, with underflow=0.
REQ-015 load (no clear) in any state SHALL set count=load_val, reload register=load_val, state=RUN next cycle, with underflow=0.
REQ-016 In RUN with enable=1 and count!=0 the block SHALL set count=count-1 next cycle.
REQ-017 In RUN with enable=1 and count==0 the block SHALL assert underflow for exactly the next cycle (terminal-count behaviour per REQ-026/027).
REQ-018 In RUN with enable=0, count and state SHALL hold and underflow SHALL be 0.
REQ-019 In IDLE and DONE, enable SHALL be ignored and count SHALL hold.
REQ-020 Load with load_val=0 SHALL enter RUN with count=0, so the first enabled cycle underflows.
REQ-021 Decrement SHALL be modulo 2^WIDTH; count never goes below 0 except via REQ-027 reload.
REQ-022 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both registered with the state.
REQ-023 Latency from load/clear/enable sample to count/flag update SHALL be one clock.

Reset
REQ-024 While rst_n=0 the block SHALL asynchronously force count=0, reload register=0, underflow=0, state=IDLE (busy=0, done=0).
REQ-025 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for load.

Configuration
REQ-026 Without macro DOWN_COUNTER_RELOAD_EN (one-shot), terminal count SHALL move to DONE with count holding 0; DONE persists until load or clear.
REQ-027 With DOWN_COUNTER_RELOAD_EN defined (auto-reload), terminal count SHALL set count=reload register and remain in RUN; DONE SHALL be unreachable and done SHALL stay 0.

Verification
REQ-028 Reset: rst_n low mid-count at count=0x37 -> count=0, underflow=0, busy=0, done=0 immediately, without a clock edge.
REQ-029 One-shot: load 0x03, enable high -> count 3,2,1,0, then underflow=1 for one cycle, done=1, busy=0, count stays 0 with enable held.
REQ-030 Auto-reload (macro on): load 0x02, enable high -> count 2,1,0,2,1,0,... with underflow pulsed once per 3 cycles, done=0 throughout.
REQ-031 Priority: load=1, clear=1, enable=1 same cycle at count=0x10 -> count=0, IDLE; then load=1 with enable=1 and load_val=0x05 -> count=0x05, RUN, no decrement that cycle.
REQ-032 Stall and zero load: load 0x00, enable low 4 cycles -> count=0, busy=1, no underflow; enable high one cycle -> underflow=1 next cycle.
REQ-033 Width: WIDTH=4, load 0xF, enable 16 cycles -> underflow on 16th enabled cycle; count never exceeds 0xF.
